// File: rtl/traffic_phase_ctrl.sv
// ---------------------------------------------------------------------------
// traffic_phase_ctrl
//
// Purpose: sequences a two-road intersection with an optional pedestrian
// phase.  The controller does not count time itself; it loads the duration
// of each phase onto timer_value for an external countdown counter and
// advances when that counter reports zero.
//
// Ports:
//   clk           rising-edge clock for all state
//   reset         synchronous, active-low reset
//   counter_value remaining ticks reported by the downstream countdown
//   ped_req       pedestrian request (single-cycle pulse or level)
//   timer_value   registered duration of the current phase (counter load)
//   main_light    {R,Y,G} one-hot for the main road
//   side_light    {R,Y,G} one-hot for the side road
//   ped_walk      walk indication, high only in the pedestrian phase
//   phase         current state encoding
//   ped_pending   latched pedestrian request not yet served
// ---------------------------------------------------------------------------
module traffic_phase_ctrl #(
    parameter int T_MAIN_G = 32'd20,
    parameter int T_SIDE_G = 32'd15,
    parameter int T_YEL    = 32'd3,
    parameter int T_CLR    = 32'd2,
    parameter int T_WALK   = 32'd10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] counter_value,
    input  logic       ped_req,
    output logic [5:0] timer_value,
    output logic [2:0] main_light,
    output logic [2:0] side_light,
    output logic       ped_walk,
    output logic [2:0] phase,
    output logic       ped_pending
);

    typedef enum logic [2:0] {
        MAIN_G = 3'd0,
        MAIN_Y = 3'd1,
        CLR_A  = 3'd2,
        SIDE_G = 3'd3,
        SIDE_Y = 3'd4,
        PED    = 3'd5,
        CLR_B  = 3'd6
    } phase_t;

    localparam logic [2:0] LIGHT_R = 3'b100;
    localparam logic [2:0] LIGHT_Y = 3'b010;
    localparam logic [2:0] LIGHT_G = 3'b001;

    // Every duration must fit the 6-bit counter and be nonzero, and each
    // phase must differ in length from the one that follows it.
    localparam bit RANGE_OK =
        (T_MAIN_G >= 32'd1) && (T_MAIN_G <= 32'd63) &&
        (T_SIDE_G >= 32'd1) && (T_SIDE_G <= 32'd63) &&
        (T_YEL    >= 32'd1) && (T_YEL    <= 32'd63) &&
        (T_CLR    >= 32'd1) && (T_CLR    <= 32'd63) &&
        (T_WALK   >= 32'd1) && (T_WALK   <= 32'd63);

    localparam bit PAIRS_OK =
        (T_MAIN_G != T_YEL)    &&   // MAIN_G -> MAIN_Y
        (T_YEL    != T_CLR)    &&   // MAIN_Y -> CLR_A, SIDE_Y -> CLR_B
        (T_CLR    != T_SIDE_G) &&   // CLR_A  -> SIDE_G
        (T_SIDE_G != T_YEL)    &&   // SIDE_G -> SIDE_Y
        (T_YEL    != T_WALK)   &&   // SIDE_Y -> PED
        (T_WALK   != T_CLR)    &&   // PED    -> CLR_B
        (T_CLR    != T_MAIN_G);     // CLR_B  -> MAIN_G

    generate
        if (!(RANGE_OK && PAIRS_OK)) begin : g_param_check
            $error("traffic_phase_ctrl: duration out of 1..63 or consecutive durations equal");
        end
    endgenerate

    // Duration loaded onto the counter when a phase is entered.
    function automatic logic [5:0] dur_of(input phase_t s);
        logic [5:0] d;
        case (s)
            MAIN_G:  d = 6'(T_MAIN_G);
            MAIN_Y:  d = 6'(T_YEL);
            CLR_A:   d = 6'(T_CLR);
            SIDE_G:  d = 6'(T_SIDE_G);
            SIDE_Y:  d = 6'(T_YEL);
            PED:     d = 6'(T_WALK);
            CLR_B:   d = 6'(T_CLR);
            default: d = 6'(T_MAIN_G);
        endcase
        return d;
    endfunction

    function automatic logic [2:0] main_of(input phase_t s);
        logic [2:0] l;
        case (s)
            MAIN_G:  l = LIGHT_G;
            MAIN_Y:  l = LIGHT_Y;
            default: l = LIGHT_R;
        endcase
        return l;
    endfunction

    function automatic logic [2:0] side_of(input phase_t s);
        logic [2:0] l;
        case (s)
            SIDE_G:  l = LIGHT_G;
            SIDE_Y:  l = LIGHT_Y;
            default: l = LIGHT_R;
        endcase
        return l;
    endfunction

    // Kept as a plain vector so an out-of-range code is representable and
    // recoverable.
    logic [2:0] state_r;
    logic       armed_r;
    logic [5:0] timer_value_r;
    logic [2:0] main_light_r;
    logic [2:0] side_light_r;
    logic       ped_walk_r;
    logic       ped_pending_r;

    phase_t     state_next_s;
    logic       advance_s;
    logic       change_s;
    logic       armed_next_s;
    logic       ped_pending_next_s;

    // Next-state, arming and pedestrian-latch decisions.
    always_comb begin
        state_next_s       = MAIN_G;
        advance_s          = (counter_value == 6'd0) && armed_r;
        change_s           = 1'b0;
        armed_next_s       = armed_r;
        ped_pending_next_s = ped_pending_r;

        case (state_r)
            MAIN_G: begin
                if (advance_s) begin
                    state_next_s = MAIN_Y;
                end else begin
                    state_next_s = MAIN_G;
                end
            end
            MAIN_Y: begin
                if (advance_s) begin
                    state_next_s = CLR_A;
                end else begin
                    state_next_s = MAIN_Y;
                end
            end
            CLR_A: begin
                if (advance_s) begin
                    state_next_s = SIDE_G;
                end else begin
                    state_next_s = CLR_A;
                end
            end
            SIDE_G: begin
                if (advance_s) begin
                    state_next_s = SIDE_Y;
                end else begin
                    state_next_s = SIDE_G;
                end
            end
            SIDE_Y: begin
                if (advance_s && ped_pending_r) begin
                    state_next_s = PED;
                end else if (advance_s) begin
                    state_next_s = CLR_B;
                end else begin
                    state_next_s = SIDE_Y;
                end
            end
            PED: begin
                if (advance_s) begin
                    state_next_s = CLR_B;
                end else begin
                    state_next_s = PED;
                end
            end
            CLR_B: begin
                if (advance_s) begin
                    state_next_s = MAIN_G;
                end else begin
                    state_next_s = CLR_B;
                end
            end
            default: begin
                // Illegal code 7 falls back to the main-road green.
                state_next_s = MAIN_G;
            end
        endcase

        change_s = (3'(state_next_s) != state_r);

        // A zero seen before any nonzero in this phase is stale and ignored.
        if (change_s) begin
            armed_next_s = 1'b0;
        end else if (counter_value != 6'd0) begin
            armed_next_s = 1'b1;
        end else begin
            armed_next_s = armed_r;
        end

        // Entering PED serves the request; a request on that edge is absorbed.
        if (change_s && (state_next_s == PED)) begin
            ped_pending_next_s = 1'b0;
        end else if (ped_req) begin
            ped_pending_next_s = 1'b1;
        end else begin
            ped_pending_next_s = ped_pending_r;
        end
    end

    // State and registered outputs, all derived from the next state so they
    // change on the same edge as the phase.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r       <= MAIN_G;
            armed_r       <= 1'b0;
            timer_value_r <= 6'(T_MAIN_G);
            main_light_r  <= LIGHT_G;
            side_light_r  <= LIGHT_R;
            ped_walk_r    <= 1'b0;
            ped_pending_r <= 1'b0;
        end else begin
            state_r       <= state_next_s;
            armed_r       <= armed_next_s;
            timer_value_r <= dur_of(state_next_s);
            main_light_r  <= main_of(state_next_s);
            side_light_r  <= side_of(state_next_s);
            ped_walk_r    <= (state_next_s == PED);
            ped_pending_r <= ped_pending_next_s;
        end
    end

    assign phase       = state_r;
    assign timer_value = timer_value_r;
    assign main_light  = main_light_r;
    assign side_light  = side_light_r;
    assign ped_walk    = ped_walk_r;
    assign ped_pending = ped_pending_r;

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// ---------------------------------------------------------------------------
// tb_traffic_phase_ctrl
//
// Directed bench for traffic_phase_ctrl with default durations
// (20/15/3/2/10).  Inputs change #1 after a rising edge; outputs are
// sampled at the same point, after the edge has settled.
// ---------------------------------------------------------------------------
module tb_traffic_phase_ctrl;

    logic       clk;
    logic       reset;
    logic [5:0] counter_value;
    logic       ped_req;
    logic [5:0] timer_value;
    logic [2:0] main_light;
    logic [2:0] side_light;
    logic       ped_walk;
    logic [2:0] phase;
    logic       ped_pending;

    int checks;
    int errors;

    traffic_phase_ctrl dut (
        .clk           (clk),
        .reset         (reset),
        .counter_value (counter_value),
        .ped_req       (ped_req),
        .timer_value   (timer_value),
        .main_light    (main_light),
        .side_light    (side_light),
        .ped_walk      (ped_walk),
        .phase         (phase),
        .ped_pending   (ped_pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [5:0] obs, input logic [5:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock edge, then a check that both roads are never non-red together.
    task automatic tick();
        @(posedge clk);
        #1;
        checks++;
        assert (!((main_light !== 3'b100) && (side_light !== 3'b100))) else begin
            errors++;
            $error("FAIL safe observed main=%b side=%b expected at least one 100",
                   main_light, side_light);
        end
    endtask

    // Counter counts d, d-1 .. 0; the phase must hold until the edge sampling 0.
    task automatic run_phase(input int d, input logic [2:0] cur);
        for (int v = d; v >= 0; v--) begin
            counter_value = 6'(v);
            tick();
            if (v == 1) begin
                chk("hold_phase", {3'd0, phase}, {3'd0, cur});
            end
        end
    endtask

    task automatic chk_state(input string tag, input logic [2:0] ph, input logic [5:0] tv,
                             input logic [2:0] ml, input logic [2:0] sl, input logic pw);
        chk({tag, "_phase"}, {3'd0, phase}, {3'd0, ph});
        chk({tag, "_timer"}, timer_value, tv);
        chk({tag, "_main"}, {3'd0, main_light}, {3'd0, ml});
        chk({tag, "_side"}, {3'd0, side_light}, {3'd0, sl});
        chk({tag, "_walk"}, {5'd0, ped_walk}, {5'd0, pw});
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        reset         = 1'b0;
        counter_value = 6'd0;
        ped_req       = 1'b0;

        // Reset state.
        tick();
        tick();
        chk_state("reset", 3'd0, 6'd20, 3'b001, 3'b100, 1'b0);
        chk("reset_pend", {5'd0, ped_pending}, 6'd0);

        // Stale zero after reset release must not advance.
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("unarmed_phase", {3'd0, phase}, 6'd0);
            chk("unarmed_timer", timer_value, 6'd20);
        end

        // First advance, then the rest of a cycle without pedestrians.
        run_phase(20, 3'd0);
        chk_state("to_main_y", 3'd1, 6'd3, 3'b010, 3'b100, 1'b0);
        run_phase(3, 3'd1);
        chk_state("to_clr_a", 3'd2, 6'd2, 3'b100, 3'b100, 1'b0);
        run_phase(2, 3'd2);
        chk_state("to_side_g", 3'd3, 6'd15, 3'b100, 3'b001, 1'b0);
        run_phase(15, 3'd3);
        chk_state("to_side_y", 3'd4, 6'd3, 3'b100, 3'b010, 1'b0);
        run_phase(3, 3'd4);
        chk_state("to_clr_b", 3'd6, 6'd2, 3'b100, 3'b100, 1'b0);
        run_phase(2, 3'd6);
        chk_state("to_main_g", 3'd0, 6'd20, 3'b001, 3'b100, 1'b0);

        // Pedestrian pulse during SIDE_G.
        run_phase(20, 3'd0);
        run_phase(3, 3'd1);
        run_phase(2, 3'd2);
        chk("ped_side_g", {3'd0, phase}, 6'd3);
        counter_value = 6'd15;
        ped_req       = 1'b1;
        tick();
        ped_req = 1'b0;
        chk("ped_latched", {5'd0, ped_pending}, 6'd1);
        run_phase(14, 3'd3);
        chk("ped_side_y", {3'd0, phase}, 6'd4);
        chk("ped_still", {5'd0, ped_pending}, 6'd1);
        run_phase(3, 3'd4);
        chk_state("to_ped", 3'd5, 6'd10, 3'b100, 3'b100, 1'b1);
        chk("ped_served", {5'd0, ped_pending}, 6'd0);
        run_phase(10, 3'd5);
        chk_state("ped_to_clr_b", 3'd6, 6'd2, 3'b100, 3'b100, 1'b0);
        run_phase(2, 3'd6);
        chk_state("ped_to_main", 3'd0, 6'd20, 3'b001, 3'b100, 1'b0);

        // Reset in SIDE_G with a pending request, an armed zero and ped_req.
        run_phase(20, 3'd0);
        run_phase(3, 3'd1);
        run_phase(2, 3'd2);
        counter_value = 6'd9;
        ped_req       = 1'b1;
        tick();
        ped_req       = 1'b0;
        counter_value = 6'd7;
        tick();
        chk("rst_pre_pend", {5'd0, ped_pending}, 6'd1);
        chk("rst_pre_phase", {3'd0, phase}, 6'd3);
        reset         = 1'b0;
        counter_value = 6'd0;
        ped_req       = 1'b1;
        tick();
        chk_state("mid_reset", 3'd0, 6'd20, 3'b001, 3'b100, 1'b0);
        chk("mid_reset_pend", {5'd0, ped_pending}, 6'd0);
        reset   = 1'b1;
        ped_req = 1'b0;
        tick();
        chk("post_reset_hold", {3'd0, phase}, 6'd0);

        // Illegal phase code recovers to MAIN_G, unarmed.
        force dut.state_r = 3'd7;
        #1;
        release dut.state_r;
        #1;
        chk("forced_7", {3'd0, phase}, 6'd7);
        counter_value = 6'd5;
        tick();
        chk_state("recover", 3'd0, 6'd20, 3'b001, 3'b100, 1'b0);
        counter_value = 6'd0;
        tick();
        chk("recover_unarmed", {3'd0, phase}, 6'd0);
        chk("recover_timer", timer_value, 6'd20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
